fdl_ctrl: RTL
=============

FDL_CTRL -- requirements
Module: fdl_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL provide parameter FILT_N, default 4: up/down filter threshold, range 1..15.
REQ-003 The block SHALL provide parameter SETTLE, default 3: cycles of PD blanking after a code change, range 0..15.
REQ-004 The block SHALL provide parameter LOCK_CNT, default 16: number of consecutive unchanged-code valid samples needed to lock, range 1..255.
REQ-005 The block SHALL provide parameter INIT_CODE, default 4: code taken at reset, range 0..8.
REQ-006 The block SHALL have port clk_in, input, 1 bit: clock.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have port en, input, 1 bit: enables tracking.
REQ-009 The block SHALL have port pd_valid, input, 1 bit: phase-detector sample strobe.
REQ-010 The block SHALL have port pd_up, input, 1 bit: add delay.
REQ-011 The block SHALL have port pd_dn, input, 1 bit: remove delay.
REQ-012 The block SHALL have port T, output, 8 bits: delay-line select, thermometer code.
REQ-013 The block SHALL have port Tb, output, 8 bits: complement of T.
REQ-014 The block SHALL have port code, output, 4 bits: current code, 0..8.
REQ-015 The block SHALL have port locked, output, 1 bit: lock indicator.
REQ-016 The block SHALL have port at_min, output, 1 bit: code==0.
REQ-017 The block SHALL have port at_max, output, 1 bit: code==8.

Function
REQ-018 T[i] SHALL be 1 exactly when i < code; Tb SHALL equal ~T in every cycle; T, Tb, code, at_min, at_max and locked SHALL all come directly from registers.
REQ-019 The FSM SHALL have states IDLE, TRACK, SETTLE_W and LOCKED.
REQ-020 IDLE->TRACK when en=1; any state->IDLE when en=0, with code held, accumulator cleared, counters cleared and locked=0 in the next cycle.
REQ-021 A sample SHALL count only when pd_valid=1 and state is TRACK or LOCKED; pd_up=pd_dn=1 or pd_up=pd_dn=0 SHALL be a null sample: no accumulator change, but it counts toward lock.
REQ-022 A signed accumulator acc SHALL take +1 for an up sample and -1 for a dn sample.
REQ-023 When acc reaches +FILT_N, code SHALL increment on the same edge the accumulator update would occur, and acc SHALL clear.
REQ-024 When acc reaches -FILT_N, code SHALL decrement on that same edge, and acc SHALL clear.
REQ-025 Latency SHALL be: the threshold-reaching sample at edge k gives the new T/Tb/code visible after edge k.
REQ-026 Saturation: an increment at code=8 or a decrement at code=0 SHALL leave code unchanged, clear acc, and not enter SETTLE_W.
REQ-027 Code SHALL never change by more than 1 per step and never leave 0..8.
REQ-028 After a code change the FSM SHALL enter SETTLE_W for SETTLE cycles, ignoring pd_valid, then return to TRACK; with SETTLE=0 it SHALL return to TRACK directly.
REQ-029 Lock counter: +1 per counted sample that produces no code change, cleared on any code change; at LOCK_CNT, TRACK->LOCKED and locked=1.
REQ-030 In LOCKED the filter SHALL keep running; the first code change SHALL set locked=0 and go to SETTLE_W, then TRACK.
REQ-031 Saturation events in LOCKED SHALL not clear locked.
REQ-032 A reset assertion mid-operation, including mid-SETTLE_W, SHALL immediately force reset values regardless of the clock.

Reset
REQ-033 While rst_n=0 the block SHALL force: state=IDLE, code=INIT_CODE, T=thermometer(INIT_CODE), Tb=~T, acc=0, settle and lock counters=0, locked=0, at_min=(INIT_CODE==0), at_max=(INIT_CODE==8).
REQ-034 Release SHALL be synchronous to clk_in; the first state transition SHALL occur on the first rising edge with rst_n=1 and en=1.

Verification
REQ-035 Reset with defaults -> code=4, T=8'h0F, Tb=8'hF0, locked=0; en=1, then 4 pd_valid up samples -> code=5, T=8'h1F in the cycle after the 4th sample; next 3 valid samples ignored (SETTLE_W).
REQ-036 code=8, 4 up samples -> code stays 8, at_max=1, no SETTLE_W entered, Tb=8'h00.
REQ-037 Alternating up/dn samples for 16 samples at code=4 -> no code change, locked=1 after the 16th; then 4 dn samples -> code=3, locked=0.
REQ-038 pd_up=pd_dn=1 for 10 samples -> acc=0, code unchanged; en dropped mid-SETTLE_W -> IDLE next cycle, code held.
REQ-039 rst_n asserted asynchronously mid-TRACK with code=7 -> T=8'h0F and code=4 before the next edge.
REQ-040 Random PD stimulus over 10k cycles -> Tb==~T, code in 0..8, and |delta code|<=1 per cycle at every cycle.

Source files
------------

// File: rtl/fdl_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fdl_ctrl: filtered up/down delay-line code controller with lock  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fdl_ctrl #(
   parameter int FILT_N    = 4,
   parameter int SETTLE    = 3,
   parameter int LOCK_CNT  = 16,
   parameter int INIT_CODE = 4
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       en,
   input  logic       pd_valid,
   input  logic       pd_up,
   input  logic       pd_dn,
   output logic [7:0] T,
   output logic [7:0] Tb,
   output logic [3:0] code,
   output logic       locked,
   output logic       at_min,
   output logic       at_max
);

   typedef enum logic [1:0] {IDLE, TRACK, SETTLE_W, LOCKED} state_t;

   localparam logic [3:0]        c_init     = 4'(INIT_CODE);
   localparam logic signed [4:0] c_filt_pos = 5'(FILT_N);
   localparam logic signed [4:0] c_filt_neg = 5'(-FILT_N);

   function automatic logic [7:0] therm(input logic [3:0] c);
      logic [7:0] t;
      for (int i = 0; i < 8; i++) t[i] = (4'(i) < c);
      return t;
   endfunction

   state_t            state_q, state_d;
   logic [3:0]        code_q, code_d;
   logic signed [4:0] acc_q, acc_d;
   logic [3:0]        settle_q, settle_d;
   logic [7:0]        lock_q, lock_d;
   logic              locked_q, locked_d;
   logic [7:0]        T_q, Tb_q;
   logic              at_min_q, at_max_q;

   logic              w_up, w_dn, w_hit_pos, w_hit_neg, w_change;
   logic signed [4:0] w_delta, w_acc_nxt;
   logic [7:0]        w_lock_inc;

   assign w_up       = pd_up & ~pd_dn;
   assign w_dn       = pd_dn & ~pd_up;
   assign w_delta    = w_up ? 5'sd1 : (w_dn ? -5'sd1 : 5'sd0);
   assign w_acc_nxt  = acc_q + w_delta;
   assign w_hit_pos  = (w_acc_nxt == c_filt_pos);
   assign w_hit_neg  = (w_acc_nxt == c_filt_neg);
   // Threshold hits at the rails clear the filter but never move the code.
   assign w_change   = (w_hit_pos && (code_q != 4'd8)) || (w_hit_neg && (code_q != 4'd0));
   assign w_lock_inc = lock_q + 8'd1;

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      acc_d    = acc_q;
      settle_d = settle_q;
      lock_d   = lock_q;
      locked_d = locked_q;
      if (!en) begin
         state_d  = IDLE;
         acc_d    = '0;
         settle_d = '0;
         lock_d   = '0;
         locked_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: state_d = TRACK;
            SETTLE_W: begin
               if (settle_q <= 4'd1) begin
                  settle_d = '0;
                  state_d  = TRACK;
               end else begin
                  settle_d = settle_q - 4'd1;
               end
            end
            TRACK, LOCKED: begin
               if (pd_valid) begin
                  acc_d = (w_hit_pos || w_hit_neg) ? 5'sd0 : w_acc_nxt;
                  if (w_change) begin
                     code_d   = w_hit_pos ? code_q + 4'd1 : code_q - 4'd1;
                     lock_d   = '0;
                     locked_d = 1'b0;
                     if (SETTLE == 0) begin
                        state_d = TRACK;
                     end else begin
                        state_d  = SETTLE_W;
                        settle_d = 4'(SETTLE);
                     end
                  end else if (state_q == TRACK) begin
                     lock_d = w_lock_inc;
                     if (w_lock_inc == 8'(LOCK_CNT)) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         code_q   <= c_init;
         acc_q    <= '0;
         settle_q <= '0;
         lock_q   <= '0;
         locked_q <= 1'b0;
         T_q      <= therm(c_init);
         Tb_q     <= ~therm(c_init);
         at_min_q <= (c_init == 4'd0);
         at_max_q <= (c_init == 4'd8);
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         acc_q    <= acc_d;
         settle_q <= settle_d;
         lock_q   <= lock_d;
         locked_q <= locked_d;
         T_q      <= therm(code_d);
         Tb_q     <= ~therm(code_d);
         at_min_q <= (code_d == 4'd0);
         at_max_q <= (code_d == 4'd8);
      end
   end

   assign T      = T_q;
   assign Tb     = Tb_q;
   assign code   = code_q;
   assign locked = locked_q;
   assign at_min = at_min_q;
   assign at_max = at_max_q;

endmodule
`default_nettype wire
